// File: rtl/switch_mcu_pkg.sv
// Shared types and helpers for the switch MCU register file.
package switch_mcu_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Widest word the byte-merge helper handles; callers extend/truncate.
  localparam int MERGE_W    = 256;
  localparam int MERGE_BE_W = MERGE_W / 8;

  // Replace each byte of old_val whose enable bit is set with the byte of new_val.
  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]    old_val,
    input logic [MERGE_W-1:0]    new_val,
    input logic [MERGE_BE_W-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_val;
    for (int i = 0; i < MERGE_BE_W; i++) begin
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/switch_mcu_regfile_rport.sv
// One registered read port: range check, zero-entry mask, write bypass,
// and the output data/valid registers.
module switch_mcu_regfile_rport
  import switch_mcu_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [ADDR_W-1:0]   raddr,
  input  logic [DATA_W-1:0]   mem_word,
  input  logic                fwd,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid
);

  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam bit              ZERO_ON   = (ZERO_REG != 0);
  localparam bit              BYPASS_ON = (BYPASS != 0);

  logic              in_range;
  logic              is_zero;
  logic              hit;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rd_next;

  // Select the value this port would capture: masked, forwarded or stored.
  always_comb begin
    in_range = ({1'b0, raddr} < DEPTH_L);
    is_zero  = ZERO_ON && (raddr == '0);
    hit      = BYPASS_ON && fwd && (waddr == raddr);
    merged   = DATA_W'(byte_merge(MERGE_W'(mem_word), MERGE_W'(wdata), MERGE_BE_W'(wbe)));
    if (!in_range || is_zero) begin
      rd_next = '0;
    end else if (hit) begin
      rd_next = merged;
    end else begin
      rd_next = mem_word;
    end
  end

  // Output registers: capture on strobe, pulse valid for one cycle, hold data otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else if (en) begin
      rdata  <= rd_next;
      rvalid <= 1'b1;
    end else begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/switch_mcu_regfile_2r1w.sv
// Byte-enabled 1-write / 2-read register file with a hardware clear sweep.
module switch_mcu_regfile_2r1w
  import switch_mcu_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                in_clear,
  input  logic                in_wr,
  input  logic [ADDR_W-1:0]   in_waddr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [DATA_W/8-1:0] in_wbe,
  input  logic                in_rd_a,
  input  logic [ADDR_W-1:0]   in_raddr_a,
  output logic [DATA_W-1:0]   out_rdata_a,
  output logic                out_rvalid_a,
  input  logic                in_rd_b,
  input  logic [ADDR_W-1:0]   in_raddr_b,
  output logic [DATA_W-1:0]   out_rdata_b,
  output logic                out_rvalid_b,
  output logic                out_ready
);

  generate
    if (DATA_W % 8 != 0) begin : g_bad_data_w
      $error("DATA_W must be a multiple of 8");
    end
    if (DATA_W > MERGE_W) begin : g_too_wide
      $error("DATA_W exceeds byte_merge width");
    end
    if (DEPTH > 2**ADDR_W || DEPTH < 1) begin : g_bad_depth
      $error("DEPTH must be in 1..2**ADDR_W");
    end
  endgenerate

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam bit                ZERO_ON  = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_next;

  logic              ready;
  logic              wr_fire;
  logic [DATA_W-1:0] wr_word;

  // Sweep/ready sequencing: advance idx through INIT, leave on clear.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      ST_INIT: begin
        if (idx == LAST_IDX) begin
          state_next = ST_READY;
          idx_next   = '0;
        end else begin
          idx_next   = idx + ADDR_W'(1);
        end
      end
      ST_READY: begin
        if (in_clear) begin
          state_next = ST_INIT;
          idx_next   = '0;
        end else begin
          state_next = ST_READY;
        end
      end
      default: begin
        state_next = ST_INIT;
        idx_next   = '0;
      end
    endcase
  end

  // State and sweep index registers; reset restarts the sweep.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state <= ST_INIT;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Write qualification: only in READY, never alongside clear/reset, never to
  // the hard-zero entry or past the end of storage.
  always_comb begin
    ready   = (state == ST_READY);
    wr_fire = ready && in_wr && !in_clear && !in_rst &&
              ({1'b0, in_waddr} < DEPTH_L) &&
              !(ZERO_ON && (in_waddr == '0));
    wr_word = DATA_W'(byte_merge(MERGE_W'(mem[in_waddr]), MERGE_W'(in_wdata),
                                 MERGE_BE_W'(in_wbe)));
  end

  // Storage: zero the swept entry during INIT, byte-merged writes in READY.
  always_ff @(posedge in_clk) begin
    if (state == ST_INIT) begin
      mem[idx] <= '0;
    end else if (wr_fire) begin
      mem[in_waddr] <= wr_word;
    end
  end

  assign out_ready = ready;

  switch_mcu_regfile_rport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rport_a (
    .clk     (in_clk),
    .rst     (in_rst),
    .en      (ready && in_rd_a),
    .raddr   (in_raddr_a),
    .mem_word(mem[in_raddr_a]),
    .fwd     (wr_fire),
    .waddr   (in_waddr),
    .wdata   (in_wdata),
    .wbe     (in_wbe),
    .rdata   (out_rdata_a),
    .rvalid  (out_rvalid_a)
  );

  switch_mcu_regfile_rport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_rport_b (
    .clk     (in_clk),
    .rst     (in_rst),
    .en      (ready && in_rd_b),
    .raddr   (in_raddr_b),
    .mem_word(mem[in_raddr_b]),
    .fwd     (wr_fire),
    .waddr   (in_waddr),
    .wdata   (in_wdata),
    .wbe     (in_wbe),
    .rdata   (out_rdata_b),
    .rvalid  (out_rvalid_b)
  );

endmodule

// File: doc/switch_mcu_regfile_2r1w.md
Name: switch_mcu_regfile_2r1w

Overview:
Parametrised successor to the MCU register file. One byte-enabled write port and two independent registered read ports (A, B). An optional write-to-read bypass and a hard-zero entry 0. A hardware clear sequencer zeroes every entry after reset or on request. Sits between the switch MCU core and its configuration/status register space; the storage is synthesisable as distributed RAM.

Parameters:
- DATA_W, 32: data width; must be a multiple of 8 (elaboration error otherwise).
- ADDR_W, 5: address width.
- DEPTH, 32: number of entries; DEPTH ≤ 2**ADDR_W.
- ZERO_REG, 1: when 1, entry 0 always reads 0 and writes to it are discarded.
- BYPASS, 1: when 1, a same-cycle write is forwarded to a read of the same address.

Ports:
- in_clk, input, 1: clock; all logic is rising-edge.
- in_rst, input, 1: synchronous reset, active-high.
- in_clear, input, 1: request a full clear sweep; honoured only in READY.
- in_wr, input, 1: write strobe.
- in_waddr, input, ADDR_W: write address.
- in_wdata, input, DATA_W: write data.
- in_wbe, input, DATA_W/8: byte enables; bit i covers data bits [8i+7:8i].
- in_rd_a, input, 1: read strobe, port A.
- in_raddr_a, input, ADDR_W: read address, port A.
- out_rdata_a, output, DATA_W: registered read data, port A.
- out_rvalid_a, output, 1: one-cycle pulse marking new port A data.
- in_rd_b, input, 1: read strobe, port B.
- in_raddr_b, input, ADDR_W: read address, port B.
- out_rdata_b, output, DATA_W: registered read data, port B.
- out_rvalid_b, output, 1: one-cycle pulse marking new port B data.
- out_ready, output, 1: high in READY; low while clearing.

Behaviour:
- State machine has two states, INIT and READY. in_rst high at an edge forces INIT with idx=0, out_rdata_a/b=0, out_rvalid_a/b=0, out_ready=0. Reset wins over every other input.
- INIT:
  - Each edge writes 0 to entry idx, then idx increments.
  - On the edge that clears idx=DEPTH-1, go to READY; out_ready=1 from that edge on. A full sweep takes exactly DEPTH cycles after reset deasserts.
  - in_wr, in_rd_a/b and in_clear are ignored; out_rvalid_a/b stay 0; out_rdata_a/b hold their values.
- READY write: at an edge with in_wr=1, each byte i with in_wbe[i]=1 takes in_wdata's byte; other bytes are unchanged. in_wbe=0 is a no-op.
- READY read:
  - At edge N with in_rd_x=1, out_rdata_x is updated and out_rvalid_x=1 for that one cycle (latency 1).
  - Without a strobe, out_rvalid_x=0 and out_rdata_x holds.
  - Ports A and B are fully independent; equal addresses are legal.
- Same-edge write and read to the same address:
  - BYPASS=1: the read returns the byte-merged new value.
  - BYPASS=0: the read returns the pre-write value.
- ZERO_REG=1: reads of address 0 return 0 regardless of bypass; writes to 0 are dropped.
- Address ≥ DEPTH: write dropped; read returns 0 with out_rvalid pulsing normally.
- in_clear in READY:
  - Next state is INIT with idx=0; out_ready drops after that edge.
  - A write in the same cycle is dropped.
  - Reads in the same cycle are serviced with pre-clear data (bypass does not apply).
- Reset asserted mid-INIT restarts the sweep from idx 0.

Decomposition:
- Shared package switch_mcu_pkg holds:
  - the state enum (ST_INIT, ST_READY);
  - the default DATA_W/ADDR_W constants;
  - a byte-merge function (old, new, be) → merged value, reused by the write path and the bypass.
- One natural sub-module, switch_mcu_regfile_rport, instantiated twice. It contains the address-range check, zero-reg mask, bypass mux, and the out_rdata/out_rvalid registers.

Test Plan:
- Reset/init (defaults): hold in_rst=1 for 2 edges, then release → out_ready stays 0 for 32 cycles then rises. Reading A=0..31 and B=31..0 returns all 0 with a one-cycle out_rvalid per read.
- Basic write/read: write addr1=0x1234 and addr2=0x2345 with be=4'hF, then read A=1, B=2 together → next cycle out_rdata_a=0x1234, out_rdata_b=0x2345, both rvalid=1. Cycle after without strobes → rvalid=0, data held.
- Byte enables: write addr3=0xAABBCCDD be=4'hF, then addr3=0x11223344 be=4'b0101 → read returns 0xAA22CC44.
- Bypass and zero register:
  - BYPASS=1: with addr4=0, write 0xDEADBEEF and read A=4 on the same edge → 0xDEADBEEF.
  - BYPASS=0 instance: same stimulus → 0; the following read → 0xDEADBEEF.
  - Write addr0=0xFFFF, then read → 0.
- Clear with collision: in READY assert in_clear, in_wr addr5=0x55 and in_rd_a addr1 on one edge → out_rdata_a=0x1234 with rvalid=1; out_ready=0 for 32 cycles; afterwards addr1 and addr5 read 0.
- Reset mid-INIT: assert in_rst at sweep cycle 10 → out_ready stays low a further 32 cycles after release. Strobes issued during INIT produce no rvalid.
